// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: memory fetch, decode hand-off and execute feedback.
// 'master' is the sequencer side, 'slave' is the memory/datapath side.
// The step signal exists only when FETCH_SEQ_STEP_EN is defined.
interface fetch_sequencer_if;
    logic       start;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_data;
    logic [7:0] instr;
    logic       instr_valid;
    logic       exec_done;
    logic       branch_taken;
    logic [7:0] branch_offset;
    logic       halt_req;
    logic [7:0] pc;
    logic       halted;
    logic       fault;
`ifdef FETCH_SEQ_STEP_EN
    logic       step;
`endif

    modport master (
        input  start, imem_ack, imem_data, exec_done, branch_taken,
               branch_offset, halt_req,
`ifdef FETCH_SEQ_STEP_EN
        input  step,
`endif
        output imem_req, imem_addr, instr, instr_valid, pc, halted, fault
    );

    modport slave (
        output start, imem_ack, imem_data, exec_done, branch_taken,
               branch_offset, halt_req,
`ifdef FETCH_SEQ_STEP_EN
        output step,
`endif
        input  imem_req, imem_addr, instr, instr_valid, pc, halted, fault
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE -> FETCH -> DECODE -> EXEC loop with
// memory timeout fault and halt. Define FETCH_SEQ_STEP_EN to add a
// single-step wait after each instruction (advanced by bus.step).
module fetch_sequencer #(
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input logic                 clk,
    input logic                 rst,
    fetch_sequencer_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT,
`ifdef FETCH_SEQ_STEP_EN
        S_STEP_WAIT,
`endif
        S_FAULT
    } state_t;

    // Last wait count that may still see an ack; one more miss faults.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] instr_q, instr_d;
    logic [7:0] wait_q, wait_d;

    // Next-state, pc update, instruction latch and fetch wait counter.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FETCH;
                    wait_d  = 8'd0;
                end
            end
            S_FETCH: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (bus.imem_ack) begin
                    instr_d = bus.imem_data;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (bus.exec_done) begin
                    // 8-bit add wraps, so a raw offset acts as sign-extended.
                    pc_d = pc_q + 8'd1 + (bus.branch_taken ? bus.branch_offset : 8'd0);
                    if (bus.halt_req) begin
                        state_d = S_HALT;
                    end else begin
`ifdef FETCH_SEQ_STEP_EN
                        state_d = S_STEP_WAIT;
`else
                        state_d = S_FETCH;
                        wait_d  = 8'd0;
`endif
                    end
                end
            end
`ifdef FETCH_SEQ_STEP_EN
            S_STEP_WAIT: begin
                if (bus.step) begin
                    state_d = S_FETCH;
                    wait_d  = 8'd0;
                end
            end
`endif
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 8'h00;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.imem_req    = (state_q == S_FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state_q == S_DECODE);
    assign bus.pc          = pc_q;
    assign bus.halted      = (state_q == S_HALT);
    assign bus.fault       = (state_q == S_FAULT);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_fetch_sequencer;
    localparam int          TMO  = 4;
    localparam logic [7:0]  RPC  = 8'h00;

    logic clk = 1'b0;
    logic rst;
    fetch_sequencer_if bus();

    fetch_sequencer #(.RESET_PC(RPC), .MEM_TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tot_cnt++;
        if (act !== exp) $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_FETCH, M_DECODE, M_EXEC, M_WAIT, M_HALT, M_FAULT} mphase_t;
    mphase_t    m_ph;
    logic [7:0] m_pc, m_instr;
    int         m_miss;

    function automatic logic [7:0] next_pc(input logic [7:0] pc, input logic br, input logic [7:0] off);
        int t;
        t = int'(pc) + 1 + (br ? int'($signed(off)) : 0);
        t = ((t % 256) + 256) % 256;
        return t[7:0];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ph    <= M_IDLE;
            m_pc    <= RPC;
            m_instr <= 8'h00;
            m_miss  <= 0;
        end else begin
            case (m_ph)
                M_IDLE: if (bus.start) begin m_ph <= M_FETCH; m_miss <= 0; end
                M_FETCH: begin
                    if (bus.imem_ack) begin
                        m_instr <= bus.imem_data;
                        m_ph    <= M_DECODE;
                    end else if (m_miss + 1 >= TMO) m_ph <= M_FAULT;
                    else m_miss <= m_miss + 1;
                end
                M_DECODE: m_ph <= M_EXEC;
                M_EXEC: if (bus.exec_done) begin
                    m_pc <= next_pc(m_pc, bus.branch_taken, bus.branch_offset);
`ifdef FETCH_SEQ_STEP_EN
                    m_ph <= bus.halt_req ? M_HALT : M_WAIT;
`else
                    m_ph <= bus.halt_req ? M_HALT : M_FETCH;
`endif
                    m_miss <= 0;
                end
`ifdef FETCH_SEQ_STEP_EN
                M_WAIT: if (bus.step) begin m_ph <= M_FETCH; m_miss <= 0; end
`endif
                default: m_ph <= m_ph;
            endcase
        end
    end

    // Compare every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_req",    {7'd0, bus.imem_req},    {7'd0, m_ph == M_FETCH});
            chk("cmp_addr",   bus.imem_addr,           m_pc);
            chk("cmp_pc",     bus.pc,                  m_pc);
            chk("cmp_instr",  bus.instr,               m_instr);
            chk("cmp_valid",  {7'd0, bus.instr_valid}, {7'd0, m_ph == M_DECODE});
            chk("cmp_halted", {7'd0, bus.halted},      {7'd0, m_ph == M_HALT});
            chk("cmp_fault",  {7'd0, bus.fault},       {7'd0, m_ph == M_FAULT});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        bus.start = 0; bus.imem_ack = 0; bus.imem_data = 8'h00; bus.exec_done = 0;
        bus.branch_taken = 0; bus.branch_offset = 8'h00; bus.halt_req = 0;
`ifdef FETCH_SEQ_STEP_EN
        bus.step = 0;
`endif
    endtask

    // After a non-halting exec: in step mode, show start is ignored, then step.
    task automatic after_exec();
`ifdef FETCH_SEQ_STEP_EN
        chk("step_wait_req", {7'd0, bus.imem_req}, 8'd0);
        bus.start = 1; @(negedge clk); bus.start = 0;
        chk("step_start_ign", {7'd0, bus.imem_req}, 8'd0);
        bus.step = 1; @(negedge clk); bus.step = 0;
`endif
    endtask

    // Entered at a negedge with the DUT in FETCH; returns in FETCH or HALT.
    task automatic do_instr(input int ack_dly, input int ex_dly, input logic br,
                            input logic [7:0] off, input logic hr, input logic [7:0] data);
        repeat (ack_dly) @(negedge clk);
        bus.imem_ack = 1; bus.imem_data = data; @(negedge clk);
        bus.imem_ack = 0;
        chk("dec_instr", bus.instr, data);
        @(negedge clk);
        repeat (ex_dly) @(negedge clk);
        bus.exec_done = 1; bus.branch_taken = br; bus.branch_offset = off; bus.halt_req = hr;
        @(negedge clk);
        bus.exec_done = 0; bus.branch_taken = 0; bus.halt_req = 0;
        if (!hr) after_exec();
    endtask

    task automatic do_reset();
        rst = 1; @(negedge clk); rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        @(negedge clk); @(negedge clk);
        chk_en = 1;
        chk("rst_pc",     bus.pc, 8'h00);
        chk("rst_instr",  bus.instr, 8'h00);
        chk("rst_req",    {7'd0, bus.imem_req}, 8'd0);
        chk("rst_valid",  {7'd0, bus.instr_valid}, 8'd0);
        chk("rst_halted", {7'd0, bus.halted}, 8'd0);
        chk("rst_fault",  {7'd0, bus.fault}, 8'd0);

        // Basic instruction: ack on first FETCH cycle, exec_done 2 cycles later.
        rst = 0; bus.start = 1; @(negedge clk); bus.start = 0;
        chk("f1_req",  {7'd0, bus.imem_req}, 8'd1);
        chk("f1_addr", bus.imem_addr, 8'h00);
        bus.imem_ack = 1; bus.imem_data = 8'hA5; @(negedge clk); bus.imem_ack = 0;
        chk("f1_instr", bus.instr, 8'hA5);
        chk("f1_valid", {7'd0, bus.instr_valid}, 8'd1);
        chk("f1_reqlo", {7'd0, bus.imem_req}, 8'd0);
        @(negedge clk);
        chk("f1_valid_once", {7'd0, bus.instr_valid}, 8'd0);
        chk("f1_instr_hold", bus.instr, 8'hA5);
        bus.exec_done = 1; @(negedge clk); bus.exec_done = 0;
        chk("f1_pc", bus.pc, 8'h01);
        after_exec();
        chk("f1_next_addr", bus.imem_addr, 8'h01);

        // Branches and wrap-around.
        do_instr(1, 0, 1, 8'h0E, 0, 8'h11); chk("pc_to_10", bus.pc, 8'h10);
        do_instr(0, 2, 1, 8'hF0, 0, 8'h22); chk("br_neg",   bus.pc, 8'h01);
        do_instr(2, 0, 1, 8'hFB, 0, 8'h33); chk("pc_to_fd", bus.pc, 8'hFD);
        do_instr(0, 0, 1, 8'h05, 0, 8'h44); chk("br_wrap",  bus.pc, 8'h03);
        // Ack on the final allowed FETCH cycle wins over timeout.
        do_instr(TMO - 1, 1, 1, 8'hFB, 0, 8'h55); chk("ack_at_tmo", bus.pc, 8'hFF);
        chk("no_fault", {7'd0, bus.fault}, 8'd0);
        do_instr(0, 0, 0, 8'h00, 0, 8'h66); chk("inc_wrap", bus.pc, 8'h00);
        chk("wrap_addr", bus.imem_addr, 8'h00);
        do_instr(0, 0, 1, 8'h06, 0, 8'h77); chk("pc_to_07", bus.pc, 8'h07);

        // Halt: pc still advances; start/ack ignored afterwards.
        do_instr(1, 0, 0, 8'h00, 1, 8'h88);
        chk("halt_pc", bus.pc, 8'h08);
        chk("halt_flag", {7'd0, bus.halted}, 8'd1);
        bus.start = 1; bus.imem_ack = 1; bus.exec_done = 1;
        repeat (3) @(negedge clk);
        idle_inputs();
        chk("halt_hold", {7'd0, bus.halted}, 8'd1);
        chk("halt_req_lo", {7'd0, bus.imem_req}, 8'd0);
        chk("halt_pc_hold", bus.pc, 8'h08);

        // Timeout: never ack -> fault after TMO FETCH cycles.
        do_reset();
        bus.start = 1; @(negedge clk); bus.start = 0;
        for (int i = 0; i < TMO; i++) begin
            chk("tmo_req", {7'd0, bus.imem_req}, 8'd1);
            @(negedge clk);
        end
        chk("tmo_fault", {7'd0, bus.fault}, 8'd1);
        chk("tmo_req_lo", {7'd0, bus.imem_req}, 8'd0);
        bus.start = 1; bus.imem_ack = 1; repeat (2) @(negedge clk); idle_inputs();
        chk("tmo_hold", {7'd0, bus.fault}, 8'd1);

        // Reset during FETCH with ack: no latch, back to idle.
        do_reset();
        bus.start = 1; @(negedge clk); bus.start = 0;
        do_instr(0, 0, 0, 8'h00, 0, 8'h3C);
        bus.imem_ack = 1; bus.imem_data = 8'h5A; rst = 1;
        @(negedge clk);
        rst = 0; bus.imem_ack = 0;
        chk("rstack_instr", bus.instr, 8'h00);
        chk("rstack_pc",    bus.pc, RPC);
        chk("rstack_req",   {7'd0, bus.imem_req}, 8'd0);
        @(negedge clk);
        chk("rstack_idle",  {7'd0, bus.imem_req}, 8'd0);

        // Randomized traffic; the compare process does the checking.
        for (int c = 0; c < 3000; c++) begin
            rst                = ($urandom_range(0, 79) == 0);
            bus.start          = ($urandom_range(0, 3) == 0);
            bus.imem_ack       = $urandom_range(0, 1) == 1;
            bus.imem_data      = 8'($urandom);
            bus.exec_done      = ($urandom_range(0, 2) == 0);
            bus.branch_taken   = $urandom_range(0, 1) == 1;
            bus.branch_offset  = 8'($urandom);
            bus.halt_req       = ($urandom_range(0, 7) == 0);
`ifdef FETCH_SEQ_STEP_EN
            bus.step           = ($urandom_range(0, 2) == 0);
`endif
            @(negedge clk);
        end
        rst = 0;
        idle_inputs();
        @(negedge clk);
        chk_en = 0;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 Parameter MEM_TIMEOUT, default 15: max FETCH cycles waiting for imem_ack before fault, range 1..255.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  leave IDLE and begin fetching.
REQ-006 imem_req  output  1  instruction memory read request.
REQ-007 imem_addr  output  8  fetch address, equals pc.
REQ-008 imem_ack  input  1  memory response valid.
REQ-009 imem_data  input  8  fetched instruction, valid with imem_ack.
REQ-010 instr  output  8  latched current instruction.
REQ-011 instr_valid  output  1  one-cycle pulse: instr ready for decode.
REQ-012 exec_done  input  1  datapath finished executing instr.
REQ-013 branch_taken  input  1  apply branch_offset, sampled with exec_done.
REQ-014 branch_offset  input  8  two's-complement jump offset.
REQ-015 halt_req  input  1  stop after current instruction, sampled with exec_done.
REQ-016 pc  output  8  program counter register.
REQ-017 halted  output  1  high in HALT.
REQ-018 fault  output  1  high in FAULT.
REQ-019 step  input  1  single-step advance; present only when FETCH_SEQ_STEP_EN is defined.

Function
REQ-020 FSM states IDLE, FETCH, DECODE, EXEC, HALT, FAULT; exactly one active.
REQ-021 IDLE: all strobes low; start=1 -> FETCH next cycle; otherwise stay.
REQ-022 FETCH: imem_req=1, imem_addr=pc, both held stable until the cycle imem_ack=1.
REQ-023 FETCH with imem_ack=1: instr <= imem_data, imem_req deasserts next cycle, -> DECODE.
REQ-024 FETCH: wait counter increments each cycle without ack; reaching MEM_TIMEOUT without ack -> FAULT; counter clears on entry to FETCH.
REQ-025 Ack in same cycle as the timeout expiry: ack wins, -> DECODE.
REQ-026 DECODE: instr_valid=1 for exactly one cycle, -> EXEC.
REQ-027 EXEC: wait for exec_done; instr held stable.
REQ-028 EXEC with exec_done=1: pc <= pc + 1 + (branch_taken ? branch_offset : 0), modulo 256, offset sign-extended.
REQ-029 Wrap: 8'hFF + 1 -> 8'h00; 8'h02 + 1 + 8'hFC -> 8'hFF.
REQ-030 exec_done with halt_req=1: pc still updates per REQ-028, -> HALT; else -> FETCH.
REQ-031 HALT and FAULT are terminal until rst; start, ack, exec_done ignored.
REQ-032 imem_ack outside FETCH, exec_done outside EXEC, branch_taken/halt_req without exec_done: ignored.
REQ-033 pc changes only in the EXEC->exit cycle or on reset.

Reset
REQ-034 rst=1 at a clock edge: state IDLE, pc=RESET_PC, instr=8'h00, wait counter 0, imem_req=instr_valid=halted=fault=0.
REQ-035 rst overrides all other inputs in the same cycle, including mid-FETCH ack; no instr latch occurs.
REQ-036 Reset mid-operation: imem_req low in the cycle after the reset edge; fetch resumes only on a new start.

Configuration
REQ-037 Macro FETCH_SEQ_STEP_EN defined: port step exists; EXEC exit without halt goes to IDLE-equivalent wait, -> FETCH only on step=1 (start ignored after first run).
REQ-038 Macro undefined: no step port; EXEC exit goes directly to FETCH per REQ-030.

Verification
REQ-039 rst, start, ack on 1st FETCH cycle with data 8'hA5, exec_done 2 cycles later -> instr=8'hA5, one instr_valid pulse, pc 8'h00->8'h01, next imem_addr=8'h01.
REQ-040 pc=8'h10, exec_done with branch_taken=1, offset 8'hF0 -> pc=8'h01; offset 8'h05 from 8'hFD -> pc=8'h03.
REQ-041 pc=8'hFF, exec_done, no branch -> pc=8'h00, fetch from 8'h00.
REQ-042 MEM_TIMEOUT=4, never ack -> fault=1 after 4 FETCH cycles, imem_req low, state held until rst.
REQ-043 exec_done with halt_req=1 at pc=8'h07 -> pc=8'h08, halted=1, later start and ack ignored.
REQ-044 rst asserted in FETCH cycle with imem_ack=1 -> instr stays 8'h00, pc=RESET_PC, IDLE; with FETCH_SEQ_STEP_EN, step pulse required between instructions.
